// File: rtl/mem_access_unit_if.sv
// Word-wide data-memory handshake between the MEM-stage load/store unit and data memory.
interface mem_access_unit_if;
  logic [31:0] DMEM_ADDR;
  logic [31:0] DMEM_WDATA;
  logic [3:0]  DMEM_BYTE_EN;
  logic        DMEM_READ;
  logic        DMEM_WRITE;
  logic [31:0] DMEM_RDATA;
  logic        DMEM_ACK;

  modport master (
    output DMEM_ADDR, DMEM_WDATA, DMEM_BYTE_EN, DMEM_READ, DMEM_WRITE,
    input  DMEM_RDATA, DMEM_ACK
  );

  modport slave (
    input  DMEM_ADDR, DMEM_WDATA, DMEM_BYTE_EN, DMEM_READ, DMEM_WRITE,
    output DMEM_RDATA, DMEM_ACK
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns RV32I loads/stores into a word-wide memory handshake,
// stalls the pipeline via BUSYWAIT and formats load data for MEM/WB.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                IN_MEM_READ,
  input  logic                IN_MEM_WRITE,
  input  logic [2:0]          IN_FUNCT3,
  input  logic [31:0]         IN_ALU_RESULT,
  input  logic [31:0]         IN_RS2_DATA,
  output logic [31:0]         OUT_DMEM_OUT,
  output logic                BUSYWAIT,
  output logic                ADDR_FAULT,
  output logic                BUS_ERROR,
  mem_access_unit_if.master   dmem
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            r_state, w_state_next;
  logic [31:0]       r_addr, r_wdata, r_data;
  logic [3:0]        r_byte_en;
  logic              r_read, r_write, r_is_load, r_err;
  logic [CntW-1:0]   r_cnt;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;

  logic              w_req, w_fault, w_start, w_timeout;
  logic [31:0]       w_wdata;
  logic [3:0]        w_be;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  assign w_req     = IN_MEM_READ | IN_MEM_WRITE;
  assign w_timeout = (r_cnt == CntW'(TIMEOUT_CYCLES - 1));
  assign w_start   = (r_state == StIdle) && w_req && !w_fault;

  always_comb begin
    w_fault = 1'b0;
    case (IN_FUNCT3)
      3'b000, 3'b100: w_fault = 1'b0;
      3'b001, 3'b101: w_fault = IN_ALU_RESULT[0];
      3'b010:         w_fault = |IN_ALU_RESULT[1:0];
      default:        w_fault = 1'b1;
    endcase
  end

  // Store lane replication so memory can pick any lane with byte enables alone.
  always_comb begin
    w_wdata = IN_RS2_DATA;
    w_be    = 4'b1111;
    case (IN_FUNCT3[1:0])
      2'b00: begin
        w_wdata = {4{IN_RS2_DATA[7:0]}};
        w_be    = 4'b0001 << IN_ALU_RESULT[1:0];
      end
      2'b01: begin
        w_wdata = {2{IN_RS2_DATA[15:0]}};
        w_be    = IN_ALU_RESULT[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdata = IN_RS2_DATA;
        w_be    = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    BUSYWAIT     = 1'b0;
    ADDR_FAULT   = 1'b0;
    BUS_ERROR    = 1'b0;
    if (!RESET) begin
      case (r_state)
        StIdle: begin
          if (w_req) begin
            if (w_fault) begin
              ADDR_FAULT = 1'b1;
            end else begin
              BUSYWAIT     = 1'b1;
              w_state_next = StAccess;
            end
          end
        end
        StAccess: begin
          BUSYWAIT = 1'b1;
          if (dmem.DMEM_ACK || w_timeout) w_state_next = StDone;
        end
        StDone: begin
          BUS_ERROR    = r_err;
          w_state_next = StIdle;
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_byte_en <= '0;
      r_read    <= 1'b0;
      r_write   <= 1'b0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_funct3  <= '0;
      r_off     <= '0;
      r_is_load <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_start) begin
            r_addr    <= {IN_ALU_RESULT[31:2], 2'b00};
            r_wdata   <= w_wdata;
            r_byte_en <= IN_MEM_READ ? 4'b1111 : w_be;
            r_read    <= IN_MEM_READ;
            r_write   <= !IN_MEM_READ;
            r_cnt     <= '0;
            r_funct3  <= IN_FUNCT3;
            r_off     <= IN_ALU_RESULT[1:0];
            r_is_load <= IN_MEM_READ;
            r_err     <= 1'b0;
          end
        end
        StAccess: begin
          r_cnt <= r_cnt + 1'b1;
          // ACK wins over a timeout landing on the same cycle.
          if (dmem.DMEM_ACK) begin
            r_data  <= dmem.DMEM_RDATA;
            r_read  <= 1'b0;
            r_write <= 1'b0;
          end else if (w_timeout) begin
            r_data  <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem.DMEM_ADDR    = r_addr;
  assign dmem.DMEM_WDATA   = r_wdata;
  assign dmem.DMEM_BYTE_EN = r_byte_en;
  assign dmem.DMEM_READ    = r_read;
  assign dmem.DMEM_WRITE   = r_write;

  always_comb begin
    w_byte = r_data[7:0];
    case (r_off)
      2'd0:    w_byte = r_data[7:0];
      2'd1:    w_byte = r_data[15:8];
      2'd2:    w_byte = r_data[23:16];
      default: w_byte = r_data[31:24];
    endcase
  end

  assign w_half = r_off[1] ? r_data[31:16] : r_data[15:0];

  always_comb begin
    OUT_DMEM_OUT = '0;
    if (r_state == StDone && r_is_load) begin
      case (r_funct3)
        3'b000:  OUT_DMEM_OUT = {{24{w_byte[7]}}, w_byte};
        3'b100:  OUT_DMEM_OUT = {24'h0, w_byte};
        3'b001:  OUT_DMEM_OUT = {{16{w_half[15]}}, w_half};
        3'b101:  OUT_DMEM_OUT = {16'h0, w_half};
        default: OUT_DMEM_OUT = r_data;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized transaction-level bench for mem_access_unit with a per-cycle compare process.
module tb_mem_access_unit;
  localparam int unsigned TMO = 16;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IN_MEM_READ, IN_MEM_WRITE;
  logic [2:0]  IN_FUNCT3;
  logic [31:0] IN_ALU_RESULT, IN_RS2_DATA;
  logic [31:0] OUT_DMEM_OUT;
  logic        BUSYWAIT, ADDR_FAULT, BUS_ERROR;

  mem_access_unit_if dmem_if ();

  mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .IN_MEM_READ  (IN_MEM_READ),
    .IN_MEM_WRITE (IN_MEM_WRITE),
    .IN_FUNCT3    (IN_FUNCT3),
    .IN_ALU_RESULT(IN_ALU_RESULT),
    .IN_RS2_DATA  (IN_RS2_DATA),
    .OUT_DMEM_OUT (OUT_DMEM_OUT),
    .BUSYWAIT     (BUSYWAIT),
    .ADDR_FAULT   (ADDR_FAULT),
    .BUS_ERROR    (BUS_ERROR),
    .dmem         (dmem_if)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle, set by the stimulus just after each posedge.
  logic        chk_en = 1'b0;
  logic        exp_busy, exp_fault, exp_berr, exp_rd, exp_wr, exp_bus, exp_wd;
  logic [31:0] exp_out, exp_addr, exp_wdata;
  logic [3:0]  exp_be;

  // Per-transaction observations used by the literal checks.
  int          obs_busy, obs_rd_cnt, obs_berr_cnt;
  logic        obs_fault, obs_wr_seen;
  logic [31:0] obs_out, obs_addr, obs_wdata;
  logic [3:0]  obs_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("busywait", 32'(BUSYWAIT), 32'(exp_busy));
      check("addr_fault", 32'(ADDR_FAULT), 32'(exp_fault));
      check("bus_error", 32'(BUS_ERROR), 32'(exp_berr));
      check("dmem_out", OUT_DMEM_OUT, exp_out);
      check("dmem_read", 32'(dmem_if.DMEM_READ), 32'(exp_rd));
      check("dmem_write", 32'(dmem_if.DMEM_WRITE), 32'(exp_wr));
      if (exp_bus) begin
        check("dmem_addr", dmem_if.DMEM_ADDR, exp_addr);
        check("byte_en", 32'(dmem_if.DMEM_BYTE_EN), 32'(exp_be));
      end
      if (exp_wd) check("wdata", dmem_if.DMEM_WDATA, exp_wdata);
    end
  end

  function automatic logic model_fault(input logic [2:0] f3, input logic [31:0] a);
    int unsigned size;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    return 1'b1;
    endcase
    return (a % size) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'((w >> (8 * off)) & 32'hFF);
    h = 16'(w >> (off[1] ? 16 : 0));
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'h0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'd0:    return {24'h0, d[7:0]} * 32'h0101_0101;
      2'd1:    return {16'h0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'd0:    return 4'(1 << a[1:0]);
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic set_exp(input logic busy, fault, berr, rd, wr, input logic [31:0] out);
    exp_busy = busy; exp_fault = fault; exp_berr = berr;
    exp_rd = rd; exp_wr = wr; exp_out = out;
    exp_bus = 1'b0; exp_wd = 1'b0;
  endtask

  task automatic cycle();
    @(negedge CLK);
    obs_busy += int'(BUSYWAIT);
    obs_rd_cnt += int'(dmem_if.DMEM_READ);
    obs_berr_cnt += int'(BUS_ERROR);
    obs_fault |= ADDR_FAULT;
    obs_out = OUT_DMEM_OUT;
    if (dmem_if.DMEM_READ) obs_addr = dmem_if.DMEM_ADDR;
    if (dmem_if.DMEM_WRITE) begin
      obs_wr_seen = 1'b1;
      obs_wdata = dmem_if.DMEM_WDATA;
      obs_be = dmem_if.DMEM_BYTE_EN;
    end
    @(posedge CLK);
    #1;
  endtask

  // ack_at: index of the ACCESS cycle carrying ACK; >= TMO means memory never answers.
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2,
                         input int ack_at, input logic [31:0] rdata);
    logic        tmo;
    int          n_acc;
    logic [31:0] eo;
    obs_busy = 0; obs_rd_cnt = 0; obs_berr_cnt = 0; obs_fault = 1'b0; obs_wr_seen = 1'b0;
    obs_out = '0; obs_addr = '0; obs_wdata = '0; obs_be = '0;
    IN_MEM_READ = rd; IN_MEM_WRITE = wr; IN_FUNCT3 = f3;
    IN_ALU_RESULT = addr; IN_RS2_DATA = rs2;
    // Stray ACKs outside ACCESS must have no effect.
    dmem_if.DMEM_ACK = 1'($urandom_range(0, 1));
    dmem_if.DMEM_RDATA = $urandom;
    if (!(rd | wr)) begin
      set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      cycle();
      return;
    end
    if (model_fault(f3, addr)) begin
      set_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      cycle();
      return;
    end
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle();
    tmo = (ack_at >= int'(TMO));
    n_acc = tmo ? int'(TMO) : ack_at + 1;
    for (int i = 0; i < n_acc; i++) begin
      dmem_if.DMEM_ACK = (i == ack_at);
      dmem_if.DMEM_RDATA = (i == ack_at) ? rdata : $urandom;
      set_exp(1'b1, 1'b0, 1'b0, rd, !rd, '0);
      exp_bus = 1'b1;
      exp_addr = {addr[31:2], 2'b00};
      exp_be = rd ? 4'b1111 : model_be(f3, addr);
      exp_wd = !rd;
      exp_wdata = model_wdata(f3, rs2);
      cycle();
    end
    dmem_if.DMEM_ACK = 1'($urandom_range(0, 1));
    dmem_if.DMEM_RDATA = $urandom;
    eo = rd ? model_load(f3, addr[1:0], tmo ? 32'h0 : rdata) : 32'h0;
    set_exp(1'b0, 1'b0, tmo, 1'b0, 1'b0, eo);
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] lf [5];
    logic [2:0] ff [3];
    logic [2:0] f3;
    logic       rd, wr;
    logic [31:0] addr;
    int kind, ad, ack_at;
    lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    ff = '{3'd3, 3'd6, 3'd7};

    RESET = 1'b1;
    IN_MEM_READ = 1'b1; IN_MEM_WRITE = 1'b0; IN_FUNCT3 = 3'd2;
    IN_ALU_RESULT = 32'h0000_1000; IN_RS2_DATA = '0;
    dmem_if.DMEM_ACK = 1'b0; dmem_if.DMEM_RDATA = '0;
    @(posedge CLK);
    #1;
    // Reset state: registers cleared, combinational flags forced low despite a pending request.
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    exp_bus = 1'b1; exp_addr = '0; exp_be = '0; exp_wd = 1'b1; exp_wdata = '0;
    chk_en = 1'b1;
    cycle();
    RESET = 1'b0;

    run_txn(1'b1, 1'b0, 3'd0, 32'h0000_1003, '0, 0, 32'h80FF_1234);
    check("lb_out", obs_out, 32'hFFFF_FF80);
    check("lb_addr", obs_addr, 32'h0000_1000);
    check("lb_busy_cycles", obs_busy, 2);

    run_txn(1'b1, 1'b0, 3'd5, 32'h0000_1002, '0, 4, 32'h80FF_1234);
    check("lhu_out", obs_out, 32'h0000_80FF);
    check("lhu_busy_cycles", obs_busy, 6);

    run_txn(1'b0, 1'b1, 3'd0, 32'h0000_1001, 32'h1234_56AB, 1, $urandom);
    check("sb_wdata", obs_wdata, 32'hABAB_ABAB);
    check("sb_byte_en", 32'(obs_be), 32'b0010);
    check("sb_seen", 32'(obs_wr_seen), 1);
    check("sb_out", obs_out, 0);

    run_txn(1'b1, 1'b0, 3'd2, 32'h0000_1002, '0, 0, $urandom);
    check("lw_mis_fault", 32'(obs_fault), 1);
    check("lw_mis_noread", obs_rd_cnt, 0);
    run_txn(1'b1, 1'b0, 3'd3, 32'h0000_1000, '0, 0, $urandom);
    check("f3_011_fault", 32'(obs_fault), 1);
    check("f3_011_busy", obs_busy, 0);

    run_txn(1'b1, 1'b0, 3'd2, 32'h0000_2000, '0, 100, $urandom);
    check("tmo_read_cycles", obs_rd_cnt, int'(TMO));
    check("tmo_berr_cycles", obs_berr_cnt, 1);
    check("tmo_out", obs_out, 0);

    // ACK on the very last allowed cycle still completes normally.
    run_txn(1'b1, 1'b1, 3'd2, 32'h0000_3000, 32'h5555_5555, int'(TMO) - 1, 32'hCAFE_F00D);
    check("late_ack_out", obs_out, 32'hCAFE_F00D);
    check("late_ack_berr", obs_berr_cnt, 0);

    // Reset during the second ACCESS cycle, then a late ACK with no request.
    IN_MEM_READ = 1'b1; IN_MEM_WRITE = 1'b0; IN_FUNCT3 = 3'd2; IN_ALU_RESULT = 32'h0000_4000;
    dmem_if.DMEM_ACK = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle();
    set_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    cycle();
    RESET = 1'b1;
    set_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    cycle();
    RESET = 1'b0; IN_MEM_READ = 1'b0;
    dmem_if.DMEM_ACK = 1'b1; dmem_if.DMEM_RDATA = 32'hDEAD_BEEF;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    exp_bus = 1'b1; exp_addr = '0; exp_be = '0;
    cycle();
    dmem_if.DMEM_ACK = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle();

    for (int t = 0; t < 300; t++) begin
      kind = $urandom_range(0, 99);
      if (kind < 50) begin
        rd = 1'b1; wr = ($urandom_range(0, 3) == 0); f3 = lf[$urandom_range(0, 4)];
      end else if (kind < 85) begin
        rd = 1'b0; wr = 1'b1; f3 = 3'($urandom_range(0, 2));
      end else if (kind < 93) begin
        rd = 1'($urandom_range(0, 1)); wr = !rd; f3 = ff[$urandom_range(0, 2)];
      end else begin
        rd = 1'b0; wr = 1'b0; f3 = 3'($urandom_range(0, 7));
      end
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      ad = $urandom_range(0, 99);
      ack_at = (ad < 80) ? $urandom_range(0, 5) : (ad < 92) ? $urandom_range(13, 15) : 100;
      run_txn(rd, wr, f3, addr, $urandom, ack_at, $urandom);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
